// File: rtl/tx_packet_arbiter_if.sv
// tx_packet_arbiter_if: requester byte streams, UART transmitter handshake and arbiter status
interface tx_packet_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  din;
    logic        tx_done_tick;
    logic [1:0]  grant;
    logic        busy;
    modport master (
        output req_valid, req_data, req_last, tx_done_tick,
        input  req_ready, tx_start, din, grant, busy
    );
    modport slave (
        input  req_valid, req_data, req_last, tx_done_tick,
        output req_ready, tx_start, din, grant, busy
    );
endinterface

// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: round-robin packet arbiter feeding one byte at a time to a UART transmitter
module tx_packet_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    tx_packet_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, REL} state_t;
    localparam logic [1:0] LAST_IDX = 2'(NREQ - 1);
    state_t     state;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic [4:0] cnt;
    logic       last_r;
    // first valid requester found searching upward from ptr, wrapping at the last port
    always_comb begin
        winner = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req_valid[ptr + 2'(k)]) winner = ptr + 2'(k);
    end
    assign bus.req_ready = (state == SEND) ? bus.req_valid & (4'b0001 << bus.grant) : 4'b0000;
    assign bus.busy      = state != IDLE;
    // arbitration, byte handoff and burst/packet release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            bus.grant    <= 2'd0;
            cnt          <= 5'd0;
            last_r       <= 1'b0;
            bus.din      <= 8'h00;
            bus.tx_start <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            case (state)
                IDLE: if (|bus.req_valid) begin
                    bus.grant <= winner;
                    cnt       <= 5'd0;
                    state     <= SEND;
                end
                SEND: if (bus.req_valid[bus.grant]) begin
                    bus.din      <= bus.req_data[8*bus.grant +: 8];
                    bus.tx_start <= 1'b1;
                    last_r       <= bus.req_last[bus.grant];
                    cnt          <= cnt + 5'd1;
                    state        <= WAIT;
                end
                WAIT: if (bus.tx_done_tick)
                    state <= (last_r || cnt == 5'(MAX_BURST)) ? REL : SEND;
                REL: begin
                    ptr   <= (bus.grant == LAST_IDX) ? 2'd0 : bus.grant + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// tb_tx_packet_arbiter: packet-level round-robin model plus per-cycle handshake checks
module tb_tx_packet_arbiter;
    localparam int MB = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    tx_packet_arbiter_if bus();
    tx_packet_arbiter #(.NREQ(4), .MAX_BURST(MB)) dut (.clk(clk), .reset(reset), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] q [4][$];
    logic [9:0] act_log[$];
    logic [9:0] exp_log[$];
    logic [3:0] stall = 4'b0;
    logic [3:0] hs = 4'b0;
    int uart_cnt = 0;
    bit inj_done = 0;
    int mptr = 0;
    bit prev_busy = 0;
    logic [1:0] prev_grant = 2'd0;
    logic [6:0] bpat, tpat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < 4; r++) begin
            if (q[r].size() > 0 && !stall[r]) begin
                bus.req_valid[r]      = 1'b1;
                bus.req_data[8*r +: 8] = q[r][0][7:0];
                bus.req_last[r]       = q[r][0][8];
            end else begin
                bus.req_valid[r]      = 1'b0;
                bus.req_data[8*r +: 8] = 8'h00;
                bus.req_last[r]       = 1'b0;
            end
        end
    endtask

    task automatic step();
        int r;
        logic [8:0] e;
        @(negedge clk);
        if (|hs) begin
            r = 0;
            for (int i = 0; i < 4; i++) if (hs[i]) r = i;
            chk("tx_start after handshake", bus.tx_start, 1);
            chk("grant at tx_start", bus.grant, r);
            if (q[r].size() == 0) chk("handshake without data", 0, 1);
            else begin
                e = q[r].pop_front();
                chk("din at tx_start", bus.din, e[7:0]);
                act_log.push_back({2'(r), bus.din});
            end
            uart_cnt = 3;
        end else chk("tx_start without handshake", bus.tx_start, 0);
        if (prev_busy && bus.busy) chk("grant held while busy", bus.grant, prev_grant);
        prev_busy = bus.busy;
        prev_grant = bus.grant;
        bus.tx_done_tick = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) bus.tx_done_tick = 1'b1;
        end
        if (inj_done) begin
            bus.tx_done_tick = 1'b1;
            inj_done = 0;
        end
        drive();
        #1;
        hs = bus.req_ready;
        chk("req_ready legal", 32'((hs & ~bus.req_valid) == 4'b0 && $countones(hs) <= 1
            && (hs == 4'b0 || (hs == (4'b0001 << bus.grant) && bus.busy))), 1);
    endtask

    function automatic bit quiet();
        return q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0
            && uart_cnt == 0 && !bus.busy && hs == 4'b0;
    endfunction

    task automatic run_until_done(input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while (!quiet() && k < budget);
        if (!quiet()) chk("timeout waiting for idle", 0, 1);
    endtask

    task automatic run_until_log(input int n, input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while (act_log.size() < n && k < budget);
        if (act_log.size() < n) chk("timeout waiting for byte", act_log.size(), n);
    endtask

    // packet-level round robin: owner sends until last or MB bytes, then search resumes after it
    task automatic build_model();
        logic [8:0] m [4][$];
        int p, r, n;
        logic [8:0] e;
        for (int i = 0; i < 4; i++) m[i] = q[i];
        p = mptr;
        while (m[0].size() + m[1].size() + m[2].size() + m[3].size() > 0) begin
            r = p;
            while (m[r].size() == 0) r = (r + 1) % 4;
            n = 0;
            do begin
                e = m[r].pop_front();
                exp_log.push_back({2'(r), e[7:0]});
                n++;
            end while (!e[8] && n < MB && m[r].size() > 0);
            p = (r + 1) % 4;
        end
        mptr = p;
    endtask

    task automatic compare();
        int n;
        chk("transmitted byte count", act_log.size(), exp_log.size());
        n = act_log.size() < exp_log.size() ? act_log.size() : exp_log.size();
        for (int i = 0; i < n; i++) chk($sformatf("tx %0d {grant,byte}", i), act_log[i], exp_log[i]);
        act_log.delete();
        exp_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset tx_start", bus.tx_start, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset grant", bus.grant, 0);
        chk("reset req_ready", bus.req_ready, 0);
        chk("reset din", bus.din, 0);
        for (int i = 0; i < 4; i++) q[i].delete();
        act_log.delete();
        exp_log.delete();
        stall = 4'b0;
        hs = 4'b0;
        uart_cnt = 0;
        inj_done = 0;
        mptr = 0;
        prev_busy = 0;
        bus.tx_done_tick = 1'b0;
        drive();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.req_valid = 4'b0;
        bus.req_data = 32'h0;
        bus.req_last = 4'b0;
        bus.tx_done_tick = 1'b0;
        #2;
        do_reset();
        // single byte: latency and REL/IDLE timing
        q[0] = '{9'h1A5};
        build_model();
        chk("model pin single", exp_log[0], 10'h0A5);
        for (int i = 0; i < 7; i++) begin
            step();
            bpat[i] = bus.busy;
            tpat[i] = bus.tx_start;
        end
        chk("busy timeline", bpat, 7'b0111110);
        chk("tx_start timeline", tpat, 7'b0000100);
        compare();
        // ptr now 1: requester 1 wins over 0
        q[0] = '{9'h111};
        q[1] = '{9'h122};
        build_model();
        chk("model pin ptr", exp_log[0][9:8], 1);
        run_until_done(200);
        compare();
        // round robin of 2-byte packets after reset
        do_reset();
        q[0] = '{9'h001, 9'h102, 9'h003, 9'h104, 9'h005, 9'h106};
        q[2] = '{9'h021, 9'h122, 9'h023, 9'h124, 9'h025, 9'h126};
        build_model();
        chk("model pin rr 2", exp_log[2][9:8], 2);
        chk("model pin rr 4", exp_log[4], {2'd0, 8'h03});
        run_until_done(300);
        compare();
        // burst limit with another requester pending
        do_reset();
        for (int i = 0; i < 10; i++) q[1].push_back({i == 9, 8'h10 + 8'(i)});
        q[3] = '{9'h031, 9'h132};
        build_model();
        chk("model pin burst size", exp_log.size(), 12);
        chk("model pin burst 4", exp_log[4][9:8], 3);
        chk("model pin burst 6", exp_log[6], {2'd1, 8'h14});
        run_until_done(400);
        compare();
        // stall mid-packet
        q[2] = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
        build_model();
        run_until_log(2, 100);
        stall[2] = 1'b1;
        repeat (20) begin
            step();
            chk("stall busy", bus.busy, 1);
            chk("stall grant", bus.grant, 2);
        end
        stall = 4'b0;
        run_until_done(200);
        compare();
        // spurious done in IDLE and in a stalled SEND
        inj_done = 1;
        step();
        step();
        chk("idle done busy", bus.busy, 0);
        step();
        chk("idle done busy later", bus.busy, 0);
        q[0] = '{9'h051, 9'h152};
        build_model();
        run_until_log(1, 100);
        stall[0] = 1'b1;
        repeat (6) step();
        chk("stalled in send", bus.busy, 1);
        inj_done = 1;
        repeat (4) step();
        chk("send done busy", bus.busy, 1);
        chk("send done grant", bus.grant, 0);
        stall = 4'b0;
        run_until_done(200);
        compare();
        // reset while waiting for the transmitter
        q[3] = '{9'h071, 9'h072, 9'h173};
        build_model();
        run_until_log(1, 100);
        do_reset();
        q[1] = '{9'h161};
        q[3] = '{9'h163};
        build_model();
        chk("model pin after reset", exp_log[0][9:8], 1);
        run_until_done(200);
        compare();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
